duplex_output_selector: RTL

- Downstream consumer of the duplicated computation pair (channels X and Y). Each channel delivers a 3-bit result, a carry bit and a two-rail error code.
- The block registers both channels and filters transient errors with persistence counters.
- It latches permanent channel faults into a reconfiguration state machine and drives one selected result plus a two-rail system health code.
- Gives the system graceful degradation: duplex, then simplex, then fail-safe.

---
 rtl/duplex_output_selector.sv | 127 ++++++++++++
 1 files changed

// File: rtl/duplex_output_selector.sv
// Output selector for a duplicated X/Y computation pair. It filters transient channel
// errors, latches permanent faults, and degrades from duplex to simplex to fail-safe.
module duplex_output_selector #(
    parameter int unsigned FAULT_THRESH    = 3,
    parameter int unsigned MISMATCH_THRESH = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] x_data,
    input  logic       x_carry,
    input  logic       xe0,
    input  logic       xe1,
    input  logic [2:0] y_data,
    input  logic       y_carry,
    input  logic       ye0,
    input  logic       ye1,
    input  logic       clear_faults,
    output logic [2:0] z_data,
    output logic       z_carry,
    output logic       z_valid,
    output logic       ze0,
    output logic       ze1,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        DUPLEX    = 2'b00,
        SIMPLEX_X = 2'b01,
        SIMPLEX_Y = 2'b10,
        FAILSAFE  = 2'b11
    } mode_t;

    localparam logic [3:0] FT = 4'(FAULT_THRESH);
    localparam logic [3:0] MT = 4'(MISMATCH_THRESH);

    mode_t      state, state_n, rules;
    logic [3:0] x_cnt, y_cnt, m_cnt;
    logic [3:0] x_cnt_n, y_cnt_n, m_cnt_n;
    logic       x_ok, y_ok, x_fail, y_fail, differ;
    logic [3:0] x_val, y_val, z_n;
    logic       v_n;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        x_ok   = ~xe0 & xe1;
        y_ok   = ~ye0 & ye1;
        x_val  = {x_carry, x_data};
        y_val  = {y_carry, y_data};
        differ = x_val != y_val;
        rules  = clear_faults ? DUPLEX : state;

        // Default is hold: the last result stays put, flagged untrustworthy.
        z_n = {z_carry, z_data};
        v_n = 1'b0;
        case (rules)
            DUPLEX: begin
                if (x_ok) begin
                    z_n = x_val;
                    v_n = ~(y_ok & differ);
                end else if (y_ok) begin
                    z_n = y_val;
                    v_n = 1'b1;
                end
            end
            SIMPLEX_X: if (x_ok) begin z_n = x_val; v_n = 1'b1; end
            SIMPLEX_Y: if (y_ok) begin z_n = y_val; v_n = 1'b1; end
            default: ;
        endcase

        // An excluded channel's counter is parked at zero.
        x_cnt_n = (state == DUPLEX || state == SIMPLEX_X) ? (x_ok ? 4'd0 : sat_inc(x_cnt)) : 4'd0;
        y_cnt_n = (state == DUPLEX || state == SIMPLEX_Y) ? (y_ok ? 4'd0 : sat_inc(y_cnt)) : 4'd0;
        m_cnt_n = (state == DUPLEX && x_ok && y_ok && differ) ? sat_inc(m_cnt) : 4'd0;
        x_fail  = x_cnt_n >= FT;
        y_fail  = y_cnt_n >= FT;

        state_n = state;
        case (state)
            DUPLEX: begin
                if ((x_fail && y_fail) || m_cnt_n >= MT) state_n = FAILSAFE;
                else if (x_fail)                         state_n = SIMPLEX_Y;
                else if (y_fail)                         state_n = SIMPLEX_X;
            end
            SIMPLEX_X: if (x_fail) state_n = FAILSAFE;
            SIMPLEX_Y: if (y_fail) state_n = FAILSAFE;
            default: ;
        endcase

        if (clear_faults) begin
            state_n = DUPLEX;
            x_cnt_n = 4'd0;
            y_cnt_n = 4'd0;
            m_cnt_n = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DUPLEX;
            x_cnt   <= 4'd0;
            y_cnt   <= 4'd0;
            m_cnt   <= 4'd0;
            z_data  <= 3'b000;
            z_carry <= 1'b0;
            z_valid <= 1'b0;
            ze0     <= 1'b1;
            ze1     <= 1'b1;
        end else begin
            state   <= state_n;
            x_cnt   <= x_cnt_n;
            y_cnt   <= y_cnt_n;
            m_cnt   <= m_cnt_n;
            z_data  <= z_n[2:0];
            z_carry <= z_n[3];
            z_valid <= v_n;
            // 10 is never produced, so a downstream checker can treat it as a block fault.
            ze0     <= ~(v_n && state_n != FAILSAFE);
            ze1     <= 1'b1;
        end
    end

    assign mode = state;

endmodule
